fc_layer_engine: RTL and testbench
==================================

# fc_layer_engine

Parametrised fully-connected (matrix-multiply) stage for the CNN datapath. It sweeps every pixel of every channel's feature-map RAM and the matching weight-ROM words, and accumulates one signed dot product per output class. It sits after the feature-map RAM buffers and replaces the separate FC controller, read-port muxes and per-class multipliers with a single block. Unlike the earlier arrangement, where one weight stream fed every class, each class receives its own weight lane.

## Interface
Parameters:
- NUM_CHANNELS, 4: number of feature-map RAMs (one per kernel).
- FM_DEPTH, 64: words per feature-map RAM.
- NUM_CLASSES, 10: output neurons.
- DATA_W, 8: signed width of feature pixels and weights.
- ACC_W, 24: signed accumulator width. Must be ≥ 2*DATA_W.
- RD_LATENCY, 1: cycles from address to read data, for both the FM RAMs and the weight ROM.

Ports (AW = clog2(FM_DEPTH), CW = max(1, clog2(NUM_CHANNELS))):
- clock, input, 1: single clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: request a pass. Sampled only while idle.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse when all sums are final.
- fm_rd_addr, output, AW: read address broadcast to all FM RAMs.
- w_rd_addr, output, CW+AW: weight ROM address, formed as {channel, fm_rd_addr}.
- fm_q_vector, input, NUM_CHANNELS*DATA_W: concatenated FM RAM outputs. Channel c occupies bits [c*DATA_W +: DATA_W].
- w_q_vector, input, NUM_CLASSES*DATA_W: one ROM word holding one weight per class. Class k occupies bits [k*DATA_W +: DATA_W].
- sum_vector, output, NUM_CLASSES*ACC_W: per-class accumulated sums. Class k occupies bits [k*ACC_W +: ACC_W].
- sum_valid, output, 1: high while sum_vector holds a completed result.

## Operation
- FSM states:
  - IDLE → ISSUE on start.
  - ISSUE → DRAIN after the last address.
  - DRAIN → DONE when the last accumulate retires.
  - DONE → IDLE unconditionally.
- On start acceptance:
  - All accumulators clear to 0.
  - sum_valid clears.
  - The channel counter and address counter clear.
- ISSUE: one read per cycle, N = NUM_CHANNELS*FM_DEPTH reads total. Order is channel-outer, address-inner: (ch0, 0..FM_DEPTH-1), then (ch1, …).
  - The address counter wraps from FM_DEPTH-1 to 0 and increments the channel.
  - The last issued pair is (NUM_CHANNELS-1, FM_DEPTH-1).
- The channel index travels through a RD_LATENCY-deep shift register alongside a valid bit. The delayed index selects the FM lane from fm_q_vector.
- Multiply stage (registered): product_k = signed(fm_lane) × signed(w_lane_k), 2*DATA_W bits.
- Accumulate stage: acc_k += sign-extend(product_k) to ACC_W. Overflow wraps in two's complement; there is no saturation.
- Outputs:
  - sum_vector always reflects the accumulators.
  - sum_valid rises with done and holds until the next start acceptance or reset.
- start while busy or in DONE: ignored, with no queuing.
- Reset at any time:
  - FSM goes to IDLE.
  - Counters, pipeline valid bits and accumulators go to 0.
  - busy, done and sum_valid go to 0.
  - Any in-flight pass is discarded and never produces done.

## Timing
- Reset values: busy=0, done=0, sum_valid=0, sum_vector=0, fm_rd_addr=0, w_rd_addr=0.
- T is the cycle in which start=1 is sampled in IDLE. With L = RD_LATENCY:
  - Read k (k = 0…N-1) is presented on the addresses in cycle T+1+k.
  - busy is high in cycles T+1 through T+N+L+1.
  - done=1 and sum_valid=1 in cycle T+N+L+2; busy=0 in that cycle.
- Start-to-done latency is N+L+2 cycles. The earliest next start is accepted in cycle T+N+L+3.
- Addresses hold their last value when not issuing.

## Configuration
- FC_ARGMAX_EN defined:
  - Adds output class_idx, width max(1, clog2(NUM_CLASSES)), reset 0.
  - class_idx holds the index of the largest signed sum and is valid with sum_valid.
  - Ties resolve to the lowest index.
  - Computation may be a sequential scan after the last accumulate, which extends DRAIN by NUM_CLASSES cycles. done and sum_valid are deferred by the same amount.
- FC_ARGMAX_EN undefined: no class_idx port, and the timing is exactly as above.

## Test plan
All scenarios use NUM_CHANNELS=2, FM_DEPTH=4, NUM_CLASSES=3, DATA_W=8, ACC_W=24, RD_LATENCY=1 (N=8).
- All FM pixels = 1, class-k weights = k+1 → sums 8/16/24; done in exactly cycle T+11; busy high in cycles T+1..T+10; address sequence (ch0: 0,1,2,3), (ch1: 0,1,2,3).
- FM = -2, weights class0 = 3, class1 = -128, class2 = 0 → sums -48, 2048, 0, which checks sign extension.
- start held high for 20 cycles → exactly one done at T+11; a second pass starts at T+12 and its accumulators are cleared before it sums.
- reset asserted at T+5 → next cycle busy=0, sum_vector=0, no done ever; a fresh start afterwards yields the correct sums.
- ACC_W=16, FM = 127, weights = 127 for 8 reads → sum 129032 mod 2^16 = -2040 as a signed 16-bit value.
- With FC_ARGMAX_EN: sums {5, 9, 9} → class_idx=1; sums all negative {-3, -1, -7} → class_idx=1; done deferred by 3 cycles.

Source files
------------

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: streams every FM pixel with its weight-ROM word and
// accumulates one signed dot product per class. Optional argmax output under FC_ARGMAX_EN.
module fc_layer_engine #(
  parameter int NUM_CHANNELS = 4,
  parameter int FM_DEPTH     = 64,
  parameter int NUM_CLASSES  = 10,
  parameter int DATA_W       = 8,
  parameter int ACC_W        = 24,
  parameter int RD_LATENCY   = 1,
  localparam int AW = (FM_DEPTH > 1) ? $clog2(FM_DEPTH) : 1,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [AW-1:0]                   fm_rd_addr,
  output logic [CW+AW-1:0]                w_rd_addr,
  input  logic [NUM_CHANNELS*DATA_W-1:0]  fm_q_vector,
  input  logic [NUM_CLASSES*DATA_W-1:0]   w_q_vector,
  output logic [NUM_CLASSES*ACC_W-1:0]    sum_vector,
  output logic                            sum_valid
`ifdef FC_ARGMAX_EN
  ,
  output logic [((NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1)-1:0] class_idx
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for start, last result held
  // S_ISSUE | one FM/weight read per cycle
  // S_DRAIN | read/multiply/accumulate pipeline emptying (plus argmax scan)
  // S_DONE  | single-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]               ch_cnt;
  logic [AW-1:0]               addr_cnt;
  logic [RD_LATENCY-1:0]       vld_pipe;
  logic [CW-1:0]               ch_pipe [RD_LATENCY];
  logic signed [DATA_W-1:0]    fm_lane;
  logic                        prod_vld;
  logic signed [2*DATA_W-1:0]  prod [NUM_CLASSES];
  logic signed [ACC_W-1:0]     acc  [NUM_CLASSES];
  logic                        accept;
  logic                        issue;
  logic                        last_issue;
  logic                        last_retire;

  assign accept      = (state == S_IDLE) && start;
  assign issue       = (state == S_ISSUE);
  assign last_issue  = issue && (ch_cnt == CW'(NUM_CHANNELS - 1)) &&
                       (addr_cnt == AW'(FM_DEPTH - 1));
  // Once issuing has stopped, the product stage holding the final read with nothing
  // behind it means the last accumulate happens this cycle.
  assign last_retire = prod_vld && !(|vld_pipe);

`ifdef FC_ARGMAX_EN
  localparam int KW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                    scan_on;
  logic                    scan_last;
  logic [KW-1:0]           scan_cnt;
  logic [KW-1:0]           best_idx;
  logic signed [ACC_W-1:0] best_val;

  assign scan_last = scan_on && (scan_cnt == KW'(NUM_CLASSES - 1));
  assign class_idx = best_idx;

  // Sequential scan over the final sums; strict compare keeps the lowest index on ties.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_on  <= 1'b0;
      scan_cnt <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else if (state == S_DRAIN && last_retire && !scan_on) begin
      scan_on  <= 1'b1;
      scan_cnt <= '0;
    end else if (scan_on) begin
      if (scan_cnt == '0 || acc[scan_cnt] > best_val) begin
        best_val <= acc[scan_cnt];
        best_idx <= scan_cnt;
      end
      if (scan_last) scan_on  <= 1'b0;
      else           scan_cnt <= scan_cnt + KW'(1);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: begin
        busy = 1'b1;
        if (last_issue) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
`ifdef FC_ARGMAX_EN
        if (scan_last) state_nxt = S_DONE;
`else
        if (last_retire) state_nxt = S_DONE;
`endif
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ch_cnt   <= '0;
      addr_cnt <= '0;
    end else if (accept) begin
      ch_cnt   <= '0;
      addr_cnt <= '0;
    end else if (issue && !last_issue) begin
      if (addr_cnt == AW'(FM_DEPTH - 1)) begin
        addr_cnt <= '0;
        ch_cnt   <= ch_cnt + CW'(1);
      end else begin
        addr_cnt <= addr_cnt + AW'(1);
      end
    end
  end

  assign fm_rd_addr = addr_cnt;
  assign w_rd_addr  = {ch_cnt, addr_cnt};

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) ch_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= issue;
      ch_pipe[0]  <= ch_cnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        ch_pipe[i]  <= ch_pipe[i-1];
      end
    end
  end

  always_comb begin
    fm_lane = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (ch_pipe[RD_LATENCY-1] == CW'(c)) fm_lane = fm_q_vector[c*DATA_W +: DATA_W];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prod_vld <= 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) prod[k] <= '0;
    end else begin
      prod_vld <= vld_pipe[RD_LATENCY-1];
      if (vld_pipe[RD_LATENCY-1]) begin
        for (int k = 0; k < NUM_CLASSES; k++)
          prod[k] <= (2*DATA_W)'(fm_lane) *
                     (2*DATA_W)'($signed(w_q_vector[k*DATA_W +: DATA_W]));
      end
    end
  end

  // Size cast on a signed product sign-extends; sums wrap on overflow.
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      for (int k = 0; k < NUM_CLASSES; k++) acc[k] <= '0;
    end else if (prod_vld) begin
      for (int k = 0; k < NUM_CLASSES; k++) acc[k] <= acc[k] + ACC_W'(prod[k]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || accept)                          sum_valid <= 1'b0;
    else if (state == S_DRAIN && state_nxt == S_DONE) sum_valid <= 1'b1;
  end

  always_comb begin
    sum_vector = '0;
    for (int k = 0; k < NUM_CLASSES; k++) sum_vector[k*ACC_W +: ACC_W] = acc[k];
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine: a 24-bit and a 16-bit accumulator instance share
// stimulus; directed passes push hand-computed sums, a negedge monitor checks each done.
module tb_fc_layer_engine;
  localparam int NC = 2, FD = 4, NK = 3, DW = 8, L = 1, N = NC*FD;
`ifdef FC_ARGMAX_EN
  localparam int EXTRA = NK;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = N + L + 2 + EXTRA;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, done, sum_valid, busy16, done16, sum_valid16;
  logic [1:0] fm_rd_addr, fm_rd_addr16;
  logic [2:0] w_rd_addr, w_rd_addr16;
  logic [NC*DW-1:0] fm_q_vector;
  logic [NK*DW-1:0] w_q_vector;
  logic [NK*24-1:0] sum_vector;
  logic [NK*16-1:0] sum_vector16;
`ifdef FC_ARGMAX_EN
  logic [1:0] class_idx, class_idx16;
`endif

  fc_layer_engine #(.NUM_CHANNELS(NC), .FM_DEPTH(FD), .NUM_CLASSES(NK), .DATA_W(DW),
                    .ACC_W(24), .RD_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .fm_rd_addr(fm_rd_addr), .w_rd_addr(w_rd_addr), .fm_q_vector(fm_q_vector),
    .w_q_vector(w_q_vector), .sum_vector(sum_vector), .sum_valid(sum_valid)
`ifdef FC_ARGMAX_EN
    , .class_idx(class_idx)
`endif
  );

  fc_layer_engine #(.NUM_CHANNELS(NC), .FM_DEPTH(FD), .NUM_CLASSES(NK), .DATA_W(DW),
                    .ACC_W(16), .RD_LATENCY(L)) dut16 (
    .clock(clock), .reset(reset), .start(start), .busy(busy16), .done(done16),
    .fm_rd_addr(fm_rd_addr16), .w_rd_addr(w_rd_addr16), .fm_q_vector(fm_q_vector),
    .w_q_vector(w_q_vector), .sum_vector(sum_vector16), .sum_valid(sum_valid16)
`ifdef FC_ARGMAX_EN
    , .class_idx(class_idx16)
`endif
  );

  always #5 clock = ~clock;

  logic signed [7:0] fm_mem [NC][FD];
  logic signed [7:0] w_rom  [N][NK];

  always @(posedge clock) begin
    fm_q_vector <= {fm_mem[1][fm_rd_addr], fm_mem[0][fm_rd_addr]};
    w_q_vector  <= {w_rom[w_rd_addr][2], w_rom[w_rd_addr][1], w_rom[w_rd_addr][0]};
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic [71:0] v24;
    logic [47:0] v16;
    int          idx;
  } exp_t;
  exp_t sb[$];

  function automatic logic [71:0] p24(input int a, input int b, input int c);
    return {24'(c), 24'(b), 24'(a)};
  endfunction
  function automatic logic [47:0] p16(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  always @(negedge clock) begin
    if (!reset && done) begin
      check("done_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 128'(cyc), 128'(e.due));
        check("sum24", 128'(sum_vector), 128'(e.v24));
        check("sum16", 128'(sum_vector16), 128'(e.v16));
        check("sum_valid_at_done", 128'(sum_valid), 128'(1));
        check("busy_at_done", 128'(busy), 128'(0));
        check("done16_aligned", 128'(done16), 128'(1));
`ifdef FC_ARGMAX_EN
        check("class_idx", 128'(class_idx), 128'(e.idx));
        check("class_idx16", 128'(class_idx16), 128'(e.idx));
`endif
      end
    end
  end

  task automatic load_uniform(input int f, input int w0, input int w1, input int w2);
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < FD; a++) fm_mem[c][a] = 8'(f);
    for (int w = 0; w < N; w++) begin
      w_rom[w][0] = 8'(w0); w_rom[w][1] = 8'(w1); w_rom[w][2] = 8'(w2);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      check("drain_timeout", 128'(sb.size()), 128'(0));
      sb.delete();
    end
  endtask

  task automatic run_pass(input logic [71:0] e24, input logic [47:0] e16, input int idx);
    int t;
    @(negedge clock);
    start = 1'b1;
    t = cyc;
    sb.push_back('{due: t + LAT, v24: e24, v16: e16, idx: idx});
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("fm_rd_addr", 128'(fm_rd_addr), 128'(k % FD));
      check("w_rd_addr", 128'(w_rd_addr), 128'({1'(k / FD), 2'(k % FD)}));
      check("w_rd_addr16", 128'(w_rd_addr16), 128'({1'(k / FD), 2'(k % FD)}));
      check("busy_issue", 128'(busy), 128'(1));
      @(negedge clock);
    end
    for (int j = N + 1; j < LAT; j++) begin
      check("busy_drain", 128'(busy), 128'(1));
      @(negedge clock);
    end
    wait_drain(LAT + 10);
    @(negedge clock);
    check("sum_valid_held", 128'(sum_valid), 128'(1));
    check("addr_held", 128'(w_rd_addr), 128'(3'b111));
  endtask

  initial begin
    int t;
    load_uniform(0, 0, 0, 0);
    repeat (3) @(negedge clock);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_sum_valid", 128'(sum_valid), 128'(0));
    check("rst_sum_vector", 128'(sum_vector), 128'(0));
    check("rst_fm_rd_addr", 128'(fm_rd_addr), 128'(0));
    check("rst_w_rd_addr", 128'(w_rd_addr), 128'(0));
`ifdef FC_ARGMAX_EN
    check("rst_class_idx", 128'(class_idx), 128'(0));
`endif
    reset = 1'b0;

    // all ones, class weights k+1
    load_uniform(1, 1, 2, 3);
    run_pass(p24(8, 16, 24), p16(8, 16, 24), 2);

    // sign extension
    load_uniform(-2, 3, -128, 0);
    run_pass(p24(-48, 2048, 0), p16(-48, 2048, 0), 1);

    // start held high for 20 cycles: exactly two back-to-back passes
    @(negedge clock);
    start = 1'b1;
    t = cyc;
    sb.push_back('{due: t + LAT, v24: p24(-48, 2048, 0), v16: p16(-48, 2048, 0), idx: 1});
    sb.push_back('{due: t + 2*LAT + 1, v24: p24(-48, 2048, 0), v16: p16(-48, 2048, 0), idx: 1});
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == LAT + 2) begin
        check("second_pass_busy", 128'(busy), 128'(1));
        check("second_pass_cleared", 128'(sum_vector), 128'(0));
        check("second_pass_sum_valid", 128'(sum_valid), 128'(0));
      end
    end
    start = 1'b0;
    wait_drain(3*LAT);
    repeat (5) @(negedge clock);

    // reset in the middle of a pass
    load_uniform(1, 1, 2, 3);
    @(negedge clock);
    start = 1'b1;
    t = cyc;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("mid_pass_accumulating", 128'(sum_vector != 0), 128'(1));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_sum_vector", 128'(sum_vector), 128'(0));
    check("abort_sum_vector16", 128'(sum_vector16), 128'(0));
    check("abort_sum_valid", 128'(sum_valid), 128'(0));
    repeat (20) @(negedge clock);
    run_pass(p24(8, 16, 24), p16(8, 16, 24), 2);

    // wraparound in the narrow accumulator
    load_uniform(127, 127, 127, 127);
    run_pass(p24(129032, 129032, 129032), p16(-2040, -2040, -2040), 0);

    // per-channel and per-word data exercise lane select and addressing
    for (int a = 0; a < FD; a++) begin
      fm_mem[0][a] = 8'(a + 1);
      fm_mem[1][a] = -8'sd1;
    end
    for (int w = 0; w < N; w++) begin
      w_rom[w][0] = 8'sd1;
      w_rom[w][1] = 8'(w);
      w_rom[w][2] = (w >= FD) ? 8'sd1 : 8'sd0;
    end
    run_pass(p24(6, -2, -4), p16(6, -2, -4), 0);

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

endmodule
